// File: rtl/parking_lot_ctrl.sv
// Parking-lot controller: lowest-free-bay allocation plus passcode-gated exits.
// Define PARK_LOCKOUT_EN to build the timed lockout after repeated bad codes.
module parking_lot_ctrl #(
    parameter int          NUM_SLOTS   = 8,
    parameter int          SLOT_W      = $clog2(NUM_SLOTS),
    parameter int          CNT_W       = $clog2(NUM_SLOTS + 1),
    parameter int          CODE_W      = 8,
    parameter int unsigned PASSCODE    = 87,
    parameter int          MAX_FAILS   = 3,
    parameter int          LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              car_arrive,
    input  logic              car_exit,
    input  logic              code_valid,
    input  logic [SLOT_W-1:0] exit_from,
    input  logic [CODE_W-1:0] exit_code,
    output logic [SLOT_W-1:0] slot,
    output logic              can_park,
    output logic              park_deny,
    output logic [NUM_SLOTS-1:0] occupancy,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              exit_ok,
    output logic              exit_err,
    output logic              locked
);

`ifdef PARK_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int TMR_W  = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CODE,
        LOCKED
    } state_t;

    logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              locked_q, locked_d;
`else
    typedef enum logic {
        IDLE,
        WAIT_CODE
    } state_t;

    // Lockout parameters have no effect when the feature is not built.
    logic unused_cfg;
    assign unused_cfg = ^{MAX_FAILS[0], LOCK_CYCLES[0]};
`endif

    state_t               state_q, state_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [NUM_SLOTS-1:0] occupancy_q, occupancy_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 can_park_q, can_park_d;
    logic                 park_deny_q, park_deny_d;
    logic                 exit_ok_q, exit_ok_d;
    logic                 exit_err_q, exit_err_d;

    logic [SLOT_W-1:0]    free_idx;
    logic                 grant;
    logic                 exit_good;
    logic                 from_ok;
    logic                 code_ok;
    logic                 bay_taken;

    // Scan downward so the last hit is the lowest free bay.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occupancy_q[i]) begin
                free_idx = SLOT_W'(i);
            end
        end
    end

    assign grant     = car_arrive && !full_q;
    assign from_ok   = (32'(exit_from) < 32'(NUM_SLOTS));
    assign code_ok   = (exit_code == CODE_W'(PASSCODE));
    assign bay_taken = from_ok && occupancy_q[exit_from];

    always_comb begin
        state_d     = state_q;
        exit_good   = 1'b0;
        exit_ok_d   = 1'b0;
        exit_err_d  = 1'b0;
`ifdef PARK_LOCKOUT_EN
        fail_cnt_d  = fail_cnt_q;
        timer_d     = timer_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (car_exit) begin
                    state_d = WAIT_CODE;
                end
            end
            WAIT_CODE: begin
                if (!car_exit) begin
                    state_d = IDLE;
                end else if (code_valid) begin
                    if (code_ok && bay_taken) begin
                        exit_good = 1'b1;
                        exit_ok_d = 1'b1;
                        state_d   = IDLE;
`ifdef PARK_LOCKOUT_EN
                        fail_cnt_d = '0;
`endif
                    end else begin
                        exit_err_d = 1'b1;
`ifdef PARK_LOCKOUT_EN
                        if (fail_cnt_q == FAIL_W'(MAX_FAILS - 1)) begin
                            fail_cnt_d = '0;
                            timer_d    = TMR_W'(LOCK_CYCLES);
                            state_d    = LOCKED;
                        end else begin
                            fail_cnt_d = fail_cnt_q + 1'b1;
                        end
`endif
                    end
                end
            end
`ifdef PARK_LOCKOUT_EN
            LOCKED: begin
                if (timer_q <= TMR_W'(1)) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Allocation reads the pre-clear occupancy, so a freed bay waits a cycle.
    always_comb begin
        occupancy_d = occupancy_q;
        slot_d      = slot_q;
        can_park_d  = grant;
        park_deny_d = car_arrive && full_q;
        if (exit_good) begin
            occupancy_d[exit_from] = 1'b0;
        end
        if (grant) begin
            occupancy_d[free_idx] = 1'b1;
            slot_d                = free_idx;
        end
        count_d = count_q + CNT_W'(grant) - CNT_W'(exit_good);
        full_d  = (count_d == CNT_W'(NUM_SLOTS));
        empty_d = (count_d == '0);
`ifdef PARK_LOCKOUT_EN
        locked_d = (state_d == LOCKED);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            occupancy_q <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            can_park_q  <= 1'b0;
            park_deny_q <= 1'b0;
            exit_ok_q   <= 1'b0;
            exit_err_q  <= 1'b0;
`ifdef PARK_LOCKOUT_EN
            fail_cnt_q  <= '0;
            timer_q     <= '0;
            locked_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            occupancy_q <= occupancy_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            can_park_q  <= can_park_d;
            park_deny_q <= park_deny_d;
            exit_ok_q   <= exit_ok_d;
            exit_err_q  <= exit_err_d;
`ifdef PARK_LOCKOUT_EN
            fail_cnt_q  <= fail_cnt_d;
            timer_q     <= timer_d;
            locked_q    <= locked_d;
`endif
        end
    end

    assign slot      = slot_q;
    assign can_park  = can_park_q;
    assign park_deny = park_deny_q;
    assign occupancy = occupancy_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign exit_ok   = exit_ok_q;
    assign exit_err  = exit_err_q;
`ifdef PARK_LOCKOUT_EN
    assign locked    = locked_q;
`else
    assign locked    = 1'b0;
`endif

endmodule
